// File: rtl/golden_nonce_reporter_if.sv
// rtl/golden_nonce_reporter_if.sv - hit input and golden-nonce output bundle for golden_nonce_reporter
interface golden_nonce_reporter_if #(
    parameter int NONCE_WIDTH = 60,
    parameter int FIFO_DEPTH  = 8
);
    logic                           rx_hit;
    logic [NONCE_WIDTH-1:0]         rx_hit_nonce;
    logic                           tx_golden_nonce_found;
    logic [NONCE_WIDTH-1:0]         tx_golden_nonce;
    logic [$clog2(FIFO_DEPTH):0]    fifo_level;
    logic [7:0]                     overflow_count;

    modport master (
        output rx_hit,
        output rx_hit_nonce,
        input  tx_golden_nonce_found,
        input  tx_golden_nonce,
        input  fifo_level,
        input  overflow_count
    );

    modport slave (
        input  rx_hit,
        input  rx_hit_nonce,
        output tx_golden_nonce_found,
        output tx_golden_nonce,
        output fifo_level,
        output overflow_count
    );
endinterface

// File: rtl/golden_nonce_reporter.sv
// rtl/golden_nonce_reporter.sv - queues hash-core hits and presents each as a held found/nonce pair
module golden_nonce_reporter #(
    parameter int NONCE_WIDTH = 60,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 16777216,
    parameter int GAP_CYCLES  = 16777216
) (
    input  logic                    hash_clk,
    input  logic                    reset_n,
    golden_nonce_reporter_if.slave  bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    logic [NONCE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic [7:0]             ovf_count;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   found;
    logic [NONCE_WIDTH-1:0] nonce;

    logic pop;
    logic push;
    logic drop;
    logic full;
    logic empty;

    // A pop frees a slot on the same edge, so a hit arriving while full is still accepted then.
    always_comb begin
        full  = (level == FULL_LVL);
        empty = (level == '0);
        pop   = (state == IDLE) && !empty;
        push  = bus.rx_hit && (!full || pop);
        drop  = bus.rx_hit && full && !pop;
    end

    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rx_hit_nonce;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ovf_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop && (ovf_count != 8'hFF)) begin
                ovf_count <= ovf_count + 8'd1;
            end
        end
    end

    // Outputs come straight from flops so the slow-side sampler never sees a glitch.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            found <= 1'b0;
            nonce <= '0;
        end else begin
            case (state)
                IDLE: begin
                    found <= 1'b0;
                    if (!empty) begin
                        nonce <= mem[rd_ptr];
                        found <= 1'b1;
                        cnt   <= HOLD_LOAD;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (cnt == '0) begin
                        found <= 1'b0;
                        cnt   <= GAP_LOAD;
                        state <= GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    found <= 1'b0;
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    found <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_golden_nonce_found = found;
    assign bus.tx_golden_nonce       = nonce;
    assign bus.fifo_level            = level;
    assign bus.overflow_count        = ovf_count;
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// tb/tb_golden_nonce_reporter.sv - directed self-checking bench for golden_nonce_reporter
module tb_golden_nonce_reporter;
    localparam int NW    = 60;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int GAPC  = 2;

    logic hash_clk = 1'b0;
    logic reset_n  = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    golden_nonce_reporter_if #(.NONCE_WIDTH(NW), .FIFO_DEPTH(DEPTH)) bus ();

    golden_nonce_reporter #(
        .NONCE_WIDTH (NW),
        .FIFO_DEPTH  (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .hash_clk (hash_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 hash_clk = ~hash_clk;
    always @(posedge hash_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic wait_found(input string tag, input int max_wait);
        for (int w = 0; w < max_wait && !bus.tx_golden_nonce_found; w++) tick();
        check_eq(tag, 64'(bus.tx_golden_nonce_found), 64'd1);
    endtask

    // Called just after the edge that raised found; leaves off after the gap, in IDLE.
    task automatic expect_hit(input string tag, input logic [NW-1:0] exp, output int rise_cyc);
        rise_cyc = cyc;
        for (int i = 0; i < HOLD; i++) begin
            check_eq({tag, "_found_hi"}, 64'(bus.tx_golden_nonce_found), 64'd1);
            check_eq({tag, "_nonce_hold"}, 64'(bus.tx_golden_nonce), 64'(exp));
            tick();
        end
        for (int i = 0; i < GAPC; i++) begin
            check_eq({tag, "_found_gap"}, 64'(bus.tx_golden_nonce_found), 64'd0);
            check_eq({tag, "_nonce_gap"}, 64'(bus.tx_golden_nonce), 64'(exp));
            tick();
        end
    endtask

    task automatic send_hit(input logic [NW-1:0] n);
        bus.rx_hit       = 1'b1;
        bus.rx_hit_nonce = n;
        tick();
    endtask

    task automatic idle_input();
        bus.rx_hit       = 1'b0;
        bus.rx_hit_nonce = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    logic [NW-1:0] hits [6];
    logic [NW-1:0] burst [3];
    int rise [6];
    int dummy;

    initial begin
        hits[0]  = 60'h111_1111_1111_1111;
        hits[1]  = 60'h222_2222_2222_2222;
        hits[2]  = 60'h333_3333_3333_3333;
        hits[3]  = 60'h444_4444_4444_4444;
        hits[4]  = 60'h555_5555_5555_5555;
        hits[5]  = 60'h666_6666_6666_6666;
        burst[0] = 60'hA0A_0A0A_0A0A_0A0A;
        burst[1] = 60'hB0B_0B0B_0B0B_0B0B;
        burst[2] = 60'hC0C_0C0C_0C0C_0C0C;

        // Reset with rx_hit asserted must not let anything in.
        bus.rx_hit       = 1'b1;
        bus.rx_hit_nonce = 60'hFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        check_eq("rst_found", 64'(bus.tx_golden_nonce_found), 64'd0);
        check_eq("rst_nonce", 64'(bus.tx_golden_nonce), 64'd0);
        check_eq("rst_level", 64'(bus.fifo_level), 64'd0);
        check_eq("rst_ovf", 64'(bus.overflow_count), 64'd0);
        idle_input();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_eq("post_rst_found", 64'(bus.tx_golden_nonce_found), 64'd0);
        check_eq("post_rst_nonce", 64'(bus.tx_golden_nonce), 64'd0);
        check_eq("post_rst_level", 64'(bus.fifo_level), 64'd0);

        // Single hit: queued at edge N, presented after N+1.
        send_hit(60'h012_3456_789A_BCDE);
        idle_input();
        check_eq("single_level_n", 64'(bus.fifo_level), 64'd1);
        check_eq("single_found_n", 64'(bus.tx_golden_nonce_found), 64'd0);
        tick();
        expect_hit("single", 60'h012_3456_789A_BCDE, dummy);
        check_eq("single_level_end", 64'(bus.fifo_level), 64'd0);

        // Burst of three back-to-back hits, 7-cycle period.
        fork
            begin
                for (int k = 0; k < 3; k++) send_hit(burst[k]);
                idle_input();
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_found($sformatf("burst%0d_seen", k), 8);
                    expect_hit($sformatf("burst%0d", k), burst[k], rise[k]);
                end
            end
        join
        check_eq("burst_period_ab", 64'(rise[1] - rise[0]), 64'd7);
        check_eq("burst_period_bc", 64'(rise[2] - rise[1]), 64'd7);
        check_eq("burst_level_end", 64'(bus.fifo_level), 64'd0);

        // Six hits into an idle block: one popped, four queued, one dropped.
        fork
            begin
                for (int k = 0; k < 6; k++) send_hit(hits[k]);
                idle_input();
                check_eq("ovf_level", 64'(bus.fifo_level), 64'd4);
                check_eq("ovf_count1", 64'(bus.overflow_count), 64'd1);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    wait_found($sformatf("ovf%0d_seen", k), 8);
                    expect_hit($sformatf("ovf%0d", k), hits[k], rise[k]);
                end
            end
        join
        for (int i = 0; i < 10; i++) tick();
        check_eq("ovf_no_dup", 64'(bus.tx_golden_nonce_found), 64'd0);
        check_eq("ovf_level_end", 64'(bus.fifo_level), 64'd0);

        // Full FIFO in IDLE with a hit arriving on the pop edge.
        for (int k = 0; k < 5; k++) send_hit(hits[k]);
        idle_input();
        check_eq("fp_level_full", 64'(bus.fifo_level), 64'd4);
        tick();
        tick();
        tick();
        send_hit(hits[5]);
        idle_input();
        check_eq("fp_level_kept", 64'(bus.fifo_level), 64'd4);
        check_eq("fp_ovf_kept", 64'(bus.overflow_count), 64'd1);
        expect_hit("fp1", hits[1], dummy);
        for (int k = 2; k < 6; k++) begin
            wait_found($sformatf("fp%0d_seen", k), 8);
            expect_hit($sformatf("fp%0d", k), hits[k], dummy);
        end
        check_eq("fp_level_end", 64'(bus.fifo_level), 64'd0);

        // Sustained hits saturate the drop counter.
        for (int k = 0; k < 330; k++) send_hit(60'(k));
        idle_input();
        check_eq("ovf_saturate", 64'(bus.overflow_count), 64'd255);
        tick();
        tick();
        check_eq("ovf_saturate_hold", 64'(bus.overflow_count), 64'd255);

        // Reset mid-PRESENT with two hits queued.
        do_reset();
        check_eq("rst2_ovf", 64'(bus.overflow_count), 64'd0);
        for (int k = 0; k < 3; k++) send_hit(hits[k]);
        idle_input();
        check_eq("mid_found_pre", 64'(bus.tx_golden_nonce_found), 64'd1);
        check_eq("mid_level_pre", 64'(bus.fifo_level), 64'd2);
        reset_n = 1'b0;
        #1;
        check_eq("mid_found_async", 64'(bus.tx_golden_nonce_found), 64'd0);
        check_eq("mid_nonce_async", 64'(bus.tx_golden_nonce), 64'd0);
        check_eq("mid_level_async", 64'(bus.fifo_level), 64'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("mid_no_stale", 64'(bus.tx_golden_nonce_found), 64'd0);
        end
        check_eq("mid_nonce_end", 64'(bus.tx_golden_nonce), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/golden_nonce_reporter.md
Name: golden_nonce_reporter

Overview:
- Hash-clock-domain producer feeding the JTAG readout path's golden-nonce inputs (found flag plus 60-bit nonce).
- Queues hits from the hashing cores in a small FIFO.
- Presents each hit as a registered, glitch-free found/nonce pair, held for HOLD_CYCLES so the slow JTAG-side double-flop sampler can capture it across several Capture-DR reads.
- After each hit, drives a found=0 gap so the host can separate consecutive hits.

Parameters:
NONCE_WIDTH, 60, width of the hit nonce and of tx_golden_nonce
FIFO_DEPTH, 8, hit queue entries; power of 2, >= 2
HOLD_CYCLES, 16777216, hash_clk cycles each hit is presented with found=1; >= 1
GAP_CYCLES, 16777216, hash_clk cycles of found=0 after each presentation; >= 1

Ports:
hash_clk  input  1  hash clock; all logic on its rising edge
reset_n  input  1  asynchronous active-low reset
rx_hit  input  1  single-cycle hit strobe from the hashing cores
rx_hit_nonce  input  NONCE_WIDTH  nonce for the hit; valid when rx_hit=1
tx_golden_nonce_found  output  1  registered: a hit is being presented
tx_golden_nonce  output  NONCE_WIDTH  registered: nonce being presented or last presented
fifo_level  output  clog2(FIFO_DEPTH)+1  current queue occupancy
overflow_count  output  8  saturating count of dropped hits

Behaviour:
- Reset (reset_n=0, async): FIFO empty, rd/wr pointers 0, fifo_level=0, state IDLE, hold counter 0, tx_golden_nonce_found=0, tx_golden_nonce=0, overflow_count=0. Mid-operation reset discards queued hits and any hit being presented.
- FIFO write: if rx_hit=1 and (not full, or a pop occurs in the same cycle), rx_hit_nonce is written at wr_ptr, wr_ptr wraps modulo FIFO_DEPTH.
- Otherwise, a hit arriving while full is dropped and overflow_count increments, saturating at 255.
- No write-to-output bypass: a hit written into an empty FIFO is popped no earlier than the next cycle.
- FIFO pop: occurs only on the IDLE->PRESENT transition. Read head, rd_ptr wraps.
- fifo_level = writes minus pops; simultaneous push and pop leaves it unchanged.
- State machine:
  - IDLE: found=0. If FIFO not empty: pop, tx_golden_nonce<=head, found<=1, counter<=HOLD_CYCLES-1, go PRESENT.
  - PRESENT: found and nonce held constant. If counter=0: found<=0, counter<=GAP_CYCLES-1, go GAP. Else decrement.
  - GAP: found=0, tx_golden_nonce keeps last value. If counter=0 go IDLE, else decrement.
- Latency:
  - A hit sampled at edge N into an empty FIFO with state IDLE appears on outputs after edge N+1.
  - Found stays high for exactly HOLD_CYCLES cycles, then low for exactly GAP_CYCLES cycles.
  - The next queued hit is presented after the IDLE cycle that follows, so the period per hit is HOLD_CYCLES+GAP_CYCLES+1.
- Invariants:
  - tx_golden_nonce changes only on the IDLE->PRESENT edge, never while found=1.
  - found and nonce update on the same edge, both from flops with no combinational path to outputs.
  - Hits are presented in arrival order with no duplicates.
- Counter width is clog2(max(HOLD_CYCLES,GAP_CYCLES)). Counter arithmetic is unsigned and never underflows.

Test Plan:
(FIFO_DEPTH=4, HOLD_CYCLES=4, GAP_CYCLES=2 unless stated)
- Reset: drive rx_hit=1 during reset_n=0 -> all outputs 0, fifo_level=0. Deassert and hold rx_hit=0 -> outputs stay 0.
- Single hit 0x0123456789ABCDE at edge N -> after N+1: found=1, nonce=0x0123456789ABCDE for 4 cycles. Then found=0 for 2 cycles. Nonce unchanged throughout. fifo_level returns to 0.
- Burst of 3 back-to-back hits A,B,C -> presented A,B,C in order, each found=1 for 4 cycles, 7-cycle period. Nonce never changes while found=1.
- Overflow: 6 back-to-back hits into an idle block -> 1 popped, 4 queued, 1 dropped. overflow_count=1, fifo_level=4. Hits 1-5 presented in order; 300 further drops -> overflow_count saturates at 255.
- Full plus simultaneous pop: FIFO full in IDLE, hit arrives on the pop cycle -> hit accepted, fifo_level stays 4, overflow_count unchanged.
- Reset mid-PRESENT with 2 hits queued -> found=0, nonce=0, fifo_level=0 immediately. After release, no stale hit is presented.
